// File: rtl/store_rs_queue_pkg.sv
// -----------------------------------------------------------------------------
// store_rs_queue_pkg
//   Shared constants, types and helpers for the store reservation-station queue.
//   Holds the machine-wide values (word size, reorder-buffer geometry, tag
//   encodings, store opcodes and instruction field positions), the operand and
//   slot payload structs, and the operand-resolution rule used both when a
//   store is issued and while it waits in the queue.
//
//   Tag encoding: tag 0 is reserved as READY ("value already present"), so ROB
//   entries that produce results are tagged 1..RB_SIZE-1. NULL (all ones) is the
//   idle value of the emitted ROB tag.
// -----------------------------------------------------------------------------
package store_rs_queue_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int RB_SIZE      = 8;
    localparam int RB_INDEX     = 3;

    // Instruction layout: opcode in the top bits, then rs/rt/rd, imm at the bottom.
    localparam int OPCODE_WIDTH = 6;
    localparam int OPCODE_START = WORD_SIZE - 1;
    localparam int RS_START     = 25;
    localparam int RT_START     = 20;
    localparam int RD_START     = 15;
    localparam int IMM_START    = 15;

    typedef logic [WORD_SIZE-1:0]         word_t;
    typedef logic [RB_INDEX-1:0]          tag_t;
    typedef logic [OPCODE_WIDTH-1:0]      opcode_t;
    typedef logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_t;
    typedef logic [RB_SIZE-1:0]           cdb_valid_t;

    localparam tag_t    READY     = tag_t'(0);
    localparam tag_t    NULL      = {RB_INDEX{1'b1}};

    localparam opcode_t INST_SW   = 6'h2B;  // store, address = Vj - imm
    localparam opcode_t INST_SWRR = 6'h2F;  // store, address = Vj - Vk

    typedef struct packed {
        word_t v;
        tag_t  q;
    } operand_t;

    typedef struct packed {
        operand_t i;     // store data
        operand_t j;     // address base
        operand_t k;     // address offset (register or immediate)
        tag_t     dest;  // ROB tag of the store itself
    } rs_payload_t;

    // An operand still waiting on tag q takes CDB lane q when that lane is valid
    // this cycle; an operand that is already READY is never overwritten.
    function automatic operand_t resolve_operand(input word_t      v,
                                                 input tag_t       q,
                                                 input cdb_data_t  cdb_data,
                                                 input cdb_valid_t cdb_valid);
        operand_t r;
        r.v = v;
        r.q = q;
        if (q != READY && cdb_valid[q]) begin
            r.v = cdb_data[int'(q)*WORD_SIZE +: WORD_SIZE];
            r.q = READY;
        end
        return r;
    endfunction

endpackage

// File: rtl/store_rs_entry.sv
// -----------------------------------------------------------------------------
// store_rs_entry
//   One reservation-station slot: the Vi/Vj/Vk values, their Qi/Qj/Qk tags, the
//   destination ROB tag and a valid bit. Resolves operands against the CDB on
//   load and keeps snooping the CDB every cycle while occupied.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   clear         empty the slot (dispatch or flush); wins over load
//   load          write load_payload into the slot
//   load_payload  raw operands from the issue stage (tags may still be pending)
//   cdb_data      per-lane CDB values, lane r at [(r+1)*WORD_SIZE-1 : r*WORD_SIZE]
//   cdb_valid     per-lane CDB valid
//   payload       stored operands/tags/destination
//   ready         slot occupied and all three stored tags READY
// -----------------------------------------------------------------------------
module store_rs_entry
    import store_rs_queue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  rs_payload_t load_payload,
    input  cdb_data_t   cdb_data,
    input  cdb_valid_t  cdb_valid,
    output rs_payload_t payload,
    output logic        ready
);

    logic        valid_q, valid_d;
    rs_payload_t payload_q, payload_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        valid_d   = valid_q;
        payload_d = payload_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d        = 1'b1;
            payload_d.i    = resolve_operand(load_payload.i.v, load_payload.i.q, cdb_data, cdb_valid);
            payload_d.j    = resolve_operand(load_payload.j.v, load_payload.j.q, cdb_data, cdb_valid);
            payload_d.k    = resolve_operand(load_payload.k.v, load_payload.k.q, cdb_data, cdb_valid);
            payload_d.dest = load_payload.dest;
        end else if (valid_q) begin
            payload_d.i = resolve_operand(payload_q.i.v, payload_q.i.q, cdb_data, cdb_valid);
            payload_d.j = resolve_operand(payload_q.j.v, payload_q.j.q, cdb_data, cdb_valid);
            payload_d.k = resolve_operand(payload_q.k.v, payload_q.k.q, cdb_data, cdb_valid);
        end
    end

    // NOTE: flops are written with non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload is storage qualified by valid_q, so it is intentionally not reset.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign payload = payload_q;
    assign ready   = valid_q
                  && (payload_q.i.q == READY)
                  && (payload_q.j.q == READY)
                  && (payload_q.k.q == READY);

endmodule

// File: rtl/store_rs_queue.sv
// -----------------------------------------------------------------------------
// store_rs_queue
//   In-order multi-entry store reservation station. Buffers up to DEPTH issued
//   stores in a circular queue of store_rs_entry slots, lets each slot snoop the
//   per-ROB-entry CDB for missing operands, and emits (addr = Vj - Vk, data = Vi,
//   ROB tag) from the oldest slot only, through a registered valid/ready output.
//
// Build option
//   STORE_RS_FLUSH_EN  when defined, adds the flush input, which empties the
//                      queue and drops out_valid at the next edge, overriding
//                      issue and dispatch in that cycle.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   issue_valid           issue a store this cycle (ignored while full)
//   RB_index              ROB tag of the issued store
//   inst                  store instruction; opcode selects register or imm offset
//   vi, vj, vk            operand values
//   qi, qj, qk            operand tags (READY = value valid)
//   CDB_data_data/_valid  per-lane CDB broadcast
//   full                  registered, high when DEPTH slots are occupied
//   out_valid/out_ready   output handshake
//   out_addr, out_data    Vj - Vk and Vi of the emitted store
//   out_rb_index          ROB tag of the emitted store
//   flush                 (STORE_RS_FLUSH_EN only) discard all buffered stores
// -----------------------------------------------------------------------------
module store_rs_queue
    import store_rs_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic [RB_INDEX-1:0]           RB_index,
    input  logic [WORD_SIZE-1:0]          inst,
    input  logic [WORD_SIZE-1:0]          vi,
    input  logic [WORD_SIZE-1:0]          vj,
    input  logic [WORD_SIZE-1:0]          vk,
    input  logic [RB_INDEX-1:0]           qi,
    input  logic [RB_INDEX-1:0]           qj,
    input  logic [RB_INDEX-1:0]           qk,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    input  logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic                          full,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_SIZE-1:0]          out_addr,
    output logic [WORD_SIZE-1:0]          out_data,
    output logic [RB_INDEX-1:0]           out_rb_index
`ifdef STORE_RS_FLUSH_EN
    ,
    input  logic                          flush
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             out_valid_q, out_valid_d;
    word_t            out_addr_q, out_addr_d;
    word_t            out_data_q, out_data_d;
    tag_t             out_rb_index_q, out_rb_index_d;

    logic             flush_act;
    logic             issue_fire;
    logic             dispatch_fire;
    rs_payload_t      issue_payload;
    word_t            imm_ext;
    rs_payload_t      head_payload;
    logic             head_ready;

    rs_payload_t      entry_payload [DEPTH];
    logic             entry_ready   [DEPTH];

`ifdef STORE_RS_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Register-field bits only matter to the decode stage that produced vi/vj/vk.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[RS_START:IMM_START+1];

    // ---------------------------------------------------------------- issue
    always_comb begin
        issue_payload          = '0;
        imm_ext                = '0;
        imm_ext[IMM_START:0]   = inst[IMM_START:0];
        issue_payload.i.v      = vi;
        issue_payload.i.q      = qi;
        issue_payload.j.v      = vj;
        issue_payload.j.q      = qj;
        if (inst[OPCODE_START -: OPCODE_WIDTH] == INST_SWRR) begin
            issue_payload.k.v  = vk;
            issue_payload.k.q  = qk;
        end else begin
            issue_payload.k.v  = imm_ext;
            issue_payload.k.q  = READY;
        end
        issue_payload.dest     = RB_index;
    end

    assign issue_fire = issue_valid && !full_q && !flush_act;

    // ---------------------------------------------------------------- slots
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        store_rs_entry u_entry (
            .clk          (clk),
            .reset        (reset),
            .clear        (flush_act || (dispatch_fire && (head_q == PTR_W'(g)))),
            .load         (issue_fire && (tail_q == PTR_W'(g))),
            .load_payload (issue_payload),
            .cdb_data     (CDB_data_data),
            .cdb_valid    (CDB_data_valid),
            .payload      (entry_payload[g]),
            .ready        (entry_ready[g])
        );
    end

    // Only the oldest slot may leave, which keeps stores in program order even
    // when a younger slot already has all of its operands.
    assign head_payload  = entry_payload[head_q];
    assign head_ready    = entry_ready[head_q];
    assign dispatch_fire = head_ready && (!out_valid_q || out_ready) && !flush_act;

    // ------------------------------------------------- pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_act) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_fire) begin
                tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (dispatch_fire) begin
                head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            if (issue_fire && !dispatch_fire) begin
                count_d = count_q + 1'b1;
            end else if (dispatch_fire && !issue_fire) begin
                count_d = count_q - 1'b1;
            end
        end
        // Registered, so a slot freed this cycle becomes visible as free next cycle.
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // ------------------------------------------------------ output register
    always_comb begin
        out_valid_d    = out_valid_q;
        out_addr_d     = out_addr_q;
        out_data_d     = out_data_q;
        out_rb_index_d = out_rb_index_q;
        if (flush_act) begin
            out_valid_d = 1'b0;
        end else if (dispatch_fire) begin
            out_valid_d    = 1'b1;
            out_addr_d     = head_payload.j.v - head_payload.k.v;  // wraps mod 2^WORD_SIZE
            out_data_d     = head_payload.i.v;
            out_rb_index_d = head_payload.dest;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            out_rb_index_q <= NULL;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            full_q         <= full_d;
            out_valid_q    <= out_valid_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
            out_rb_index_q <= out_rb_index_d;
        end
    end

    assign full         = full_q;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign out_rb_index = out_rb_index_q;

endmodule

// File: tb/tb_store_rs_queue.sv
// -----------------------------------------------------------------------------
// tb_store_rs_queue
//   Scoreboarded bench for store_rs_queue. Accepted issues are pushed into a
//   reference queue that resolves operands from the CDB by tag; the monitor pops
//   the oldest store on each output transfer and compares address/data/tag.
//   Directed sections cover reset, latency, ordering, full/overflow, reset in
//   flight and (with STORE_RS_FLUSH_EN) flush.
// -----------------------------------------------------------------------------
module tb_store_rs_queue;
    import store_rs_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    tag_t       rb_index;
    word_t      inst, vi, vj, vk;
    tag_t       qi, qj, qk;
    cdb_data_t  cdb_data;
    cdb_valid_t cdb_valid;
    logic       full;
    logic       out_valid;
    logic       out_ready;
    word_t      out_addr, out_data;
    tag_t       out_rb_index;
`ifdef STORE_RS_FLUSH_EN
    logic       flush;
`endif

    store_rs_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .RB_index       (rb_index),
        .inst           (inst),
        .vi             (vi),
        .vj             (vj),
        .vk             (vk),
        .qi             (qi),
        .qj             (qj),
        .qk             (qk),
        .CDB_data_data  (cdb_data),
        .CDB_data_valid (cdb_valid),
        .full           (full),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_data       (out_data),
`ifdef STORE_RS_FLUSH_EN
        .flush          (flush),
`endif
        .out_rb_index   (out_rb_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------ reference model
    // Operand slot 0 = data (i), 1 = address base (j), 2 = offset (k).
    typedef struct packed {
        logic [2:0][WORD_SIZE-1:0] v;
        logic [2:0][RB_INDEX-1:0]  q;
        tag_t                      dest;
    } model_t;

    model_t mq[$];
    logic   issue_expect;   // stimulus intends this issue to be accepted
    model_t mon_e;
    model_t new_e;
    word_t  exp_addr;

    function automatic model_t model_snoop(input model_t e);
        for (int k = 0; k < 3; k++) begin
            if (e.q[k] != READY && cdb_valid[e.q[k]]) begin
                e.v[k] = cdb_data[int'(e.q[k])*WORD_SIZE +: WORD_SIZE];
                e.q[k] = READY;
            end
        end
        return e;
    endfunction

    // Sampled on the falling edge: the values seen here are the ones the next
    // rising edge acts on.
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    check("out_unexpected", 64'(out_rb_index), 64'(NULL) + 64'd1);
                end else begin
                    mon_e    = mq.pop_front();
                    exp_addr = mon_e.v[1] - mon_e.v[2];
                    check("out_operands_ready", 64'(mon_e.q), 64'd0);
                    check("out_addr", 64'(out_addr), 64'(exp_addr));
                    check("out_data", 64'(out_data), 64'(mon_e.v[0]));
                    check("out_rb_index", 64'(out_rb_index), 64'(mon_e.dest));
                end
            end
`ifdef STORE_RS_FLUSH_EN
            if (flush) begin
                mq.delete();
            end else
`endif
            begin
                for (int n = 0; n < mq.size(); n++) begin
                    mq[n] = model_snoop(mq[n]);
                end
                if (issue_valid && issue_expect) begin
                    new_e.v[0] = vi;
                    new_e.q[0] = qi;
                    new_e.v[1] = vj;
                    new_e.q[1] = qj;
                    if (inst[WORD_SIZE-1 -: OPCODE_WIDTH] == INST_SWRR) begin
                        new_e.v[2] = vk;
                        new_e.q[2] = qk;
                    end else begin
                        new_e.v[2] = inst & ((word_t'(1) << (IMM_START + 1)) - 1);
                        new_e.q[2] = READY;
                    end
                    new_e.dest = rb_index;
                    mq.push_back(model_snoop(new_e));
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input word_t i_inst, input word_t i_vi, input word_t i_vj,
                               input word_t i_vk, input tag_t i_qi, input tag_t i_qj,
                               input tag_t i_qk, input tag_t i_rb, input logic i_expect);
        issue_valid  = 1'b1;
        inst         = i_inst;
        vi           = i_vi;
        vj           = i_vj;
        vk           = i_vk;
        qi           = i_qi;
        qj           = i_qj;
        qk           = i_qk;
        rb_index     = i_rb;
        issue_expect = i_expect;
    endtask

    task automatic stop_issue();
        issue_valid  = 1'b0;
        issue_expect = 1'b0;
    endtask

    task automatic drive_lane(input int lane, input word_t value);
        cdb_valid[lane]                           = 1'b1;
        cdb_data[lane*WORD_SIZE +: WORD_SIZE]     = value;
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check(name, 64'(out_valid), 64'd0);
            step();
        end
    endtask

    task automatic wait_out_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (mq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(mq.size()), 64'd0);
    endtask

    function automatic tag_t rand_tag();
        return ($urandom_range(1) == 0) ? READY : tag_t'($urandom_range(RB_SIZE - 1, 1));
    endfunction

    word_t r_inst;

    initial begin
        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_expect = 1'b0;
        rb_index     = '0;
        inst         = '0;
        vi           = '0;
        vj           = '0;
        vk           = '0;
        qi           = READY;
        qj           = READY;
        qk           = READY;
        cdb_data     = '0;
        cdb_valid    = '0;
        out_ready    = 1'b1;
`ifdef STORE_RS_FLUSH_EN
        flush        = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;

        // Reset state held while idle.
        check("reset_out_addr", 64'(out_addr), 64'd0);
        for (int c = 0; c < 10; c++) begin
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_full", 64'(full), 64'd0);
            check("idle_out_rb_index", 64'(out_rb_index), 64'(NULL));
            step();
        end

        // Register-register store with everything ready.
        drive_issue({INST_SWRR, 26'h0}, 32'd5, 32'h100, 32'h10, READY, READY, READY, 3'd2, 1'b1);
        step();
        stop_issue();
        wait_out_valid("swrr_timeout", 5);
        check("swrr_addr", 64'(out_addr), 64'hF0);
        check("swrr_data", 64'(out_data), 64'd5);
        check("swrr_rb", 64'(out_rb_index), 64'd2);
        step();
        step();

        // Pending data operand: out_valid exactly one edge after capture.
        drive_issue({INST_SWRR, 26'h0}, 32'd0, 32'h30, 32'h8, 3'd3, READY, READY, 3'd5, 1'b1);
        step();
        stop_issue();
        expect_idle("pending_idle", 3);
        drive_lane(3, 32'hAB);
        step();
        cdb_valid = '0;
        check("latency_edge_t", 64'(out_valid), 64'd0);
        step();
        check("latency_edge_t1", 64'(out_valid), 64'd1);
        check("latency_data", 64'(out_data), 64'hAB);
        check("latency_addr", 64'(out_addr), 64'h28);
        step();
        step();

        // Fill all slots while the consumer stalls, then drain across the wrap.
        out_ready = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            check("fill_not_full", 64'(full), 64'd0);
            drive_issue({INST_SWRR, 26'h0}, 32'd0, 32'h1000 + 32'(s), 32'(s), 3'd4, READY, READY,
                        tag_t'(s + 1), 1'b1);
            step();
        end
        check("fill_full", 64'(full), 64'd1);
        drive_issue({INST_SWRR, 26'h0}, 32'h77, 32'h77, 32'h7, READY, READY, READY, 3'd6, 1'b0);
        step();
        stop_issue();
        check("overflow_still_full", 64'(full), 64'd1);
        check("overflow_no_out", 64'(out_valid), 64'd0);
        drive_lane(4, 32'h44);
        out_ready = 1'b1;
        step();
        cdb_valid = '0;
        wait_drained("fill_drain", 20);
        expect_idle("fill_no_extra", 3);
        check("fill_drained_not_full", 64'(full), 64'd0);

        // Older unready slot blocks a younger ready one.
        drive_issue({INST_SWRR, 26'h0}, 32'h11, 32'h0, 32'h22, READY, 3'd6, READY, 3'd1, 1'b1);
        step();
        drive_issue({INST_SWRR, 26'h0}, 32'h33, 32'h50, 32'h5, READY, READY, READY, 3'd3, 1'b1);
        step();
        stop_issue();
        expect_idle("order_blocked", 4);
        drive_lane(6, 32'h600);
        step();
        cdb_valid = '0;
        check("order_capture_edge", 64'(out_valid), 64'd0);
        step();
        check("order_first_valid", 64'(out_valid), 64'd1);
        check("order_first_rb", 64'(out_rb_index), 64'd1);
        check("order_first_addr", 64'(out_addr), 64'h5DE);
        step();
        check("order_second_valid", 64'(out_valid), 64'd1);
        check("order_second_rb", 64'(out_rb_index), 64'd3);
        step();
        step();

        // Reset in flight discards buffered stores.
        drive_issue({INST_SWRR, 26'h0}, 32'h1, 32'h2, 32'h3, 3'd5, READY, READY, 3'd1, 1'b1);
        step();
        drive_issue({INST_SWRR, 26'h0}, 32'h4, 32'h5, 32'h6, READY, READY, READY, 3'd2, 1'b1);
        step();
        stop_issue();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_rb", 64'(out_rb_index), 64'(NULL));
        drive_lane(5, 32'h55);
        step();
        cdb_valid = '0;
        expect_idle("midreset_idle", 4);

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(3) != 0);
            cdb_valid = '0;
            for (int l = 1; l < RB_SIZE; l++) begin
                if ($urandom_range(3) == 0) drive_lane(l, $urandom);
            end
            if (!full && $urandom_range(1) == 1) begin
                r_inst = $urandom;
                r_inst[WORD_SIZE-1 -: OPCODE_WIDTH] = ($urandom_range(1) == 1) ? INST_SWRR : INST_SW;
                drive_issue(r_inst, $urandom, $urandom, $urandom, rand_tag(), rand_tag(), rand_tag(),
                            tag_t'($urandom_range(RB_SIZE - 1)), 1'b1);
            end else begin
                stop_issue();
            end
            step();
        end
        stop_issue();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && mq.size() != 0; c++) begin
            for (int l = 1; l < RB_SIZE; l++) drive_lane(l, $urandom);
            step();
        end
        cdb_valid = '0;
        wait_drained("random_drain", 5);

`ifdef STORE_RS_FLUSH_EN
        // Flush with one store in the output register and three waiting.
        out_ready = 1'b0;
        drive_issue({INST_SWRR, 26'h0}, 32'h9, 32'h9, 32'h1, READY, READY, READY, 3'd1, 1'b1);
        step();
        for (int s = 0; s < 3; s++) begin
            drive_issue({INST_SWRR, 26'h0}, 32'h0, 32'h9, 32'h1, 3'd2, READY, READY, tag_t'(s + 2), 1'b1);
            step();
        end
        stop_issue();
        check("preflush_out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_full", 64'(full), 64'd0);
        flush = 1'b1;
        drive_issue({INST_SWRR, 26'h0}, 32'h5, 32'h6, 32'h7, READY, READY, READY, 3'd4, 1'b1);
        step();
        flush = 1'b0;
        stop_issue();
        out_ready = 1'b1;
        drive_lane(2, 32'h22);
        step();
        cdb_valid = '0;
        expect_idle("flush_issue_empty", 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
